// File: rtl/fila_carona_param_pkg.sv
// fila_carona_param shared types
// default widths and scan FSM states
package fila_carona_param_pkg;

  localparam int FLOOR_W_D = 2;
  localparam int TYPE_W_D  = 2;
  localparam int DEPTH_D   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_O,
    S_INS_O,
    S_MERGE_O,
    S_SCAN_D,
    S_INS_D,
    S_MERGE_D
  } state_t;

endpackage

// File: rtl/fila_carona_param_if.sv
// fila_carona_param request/pop bus
// master = requester/UC side, slave = queue
interface fila_carona_param_if
  import fila_carona_param_pkg::*;
#(
  parameter int FLOOR_W = FLOOR_W_D,
  parameter int TYPE_W  = TYPE_W_D
);

  logic               req_valid;
  logic               req_ready;
  logic [FLOOR_W-1:0] req_origem;
  logic [FLOOR_W-1:0] req_destino;
  logic [TYPE_W-1:0]  req_tipo;
  logic               pop;
  logic               pop_ready;
  logic               head_valid;
  logic [FLOOR_W-1:0] head_andar;
  logic               head_eh_origem;
  logic [TYPE_W-1:0]  head_tipo;
  logic               sobe;

  modport master (
    output req_valid, req_origem,
    output req_destino, req_tipo, pop,
    input  req_ready, pop_ready,
    input  head_valid, head_andar,
    input  head_eh_origem, head_tipo, sobe
  );

  modport slave (
    input  req_valid, req_origem,
    input  req_destino, req_tipo, pop,
    output req_ready, pop_ready,
    output head_valid, head_andar,
    output head_eh_origem, head_tipo, sobe
  );

endinterface

// File: rtl/fila_carona_param_janela.sv
// fila_carona_param en-route window
// decides if alvo lies on the leg prev->cur
module fila_carona_param_janela
  import fila_carona_param_pkg::*;
#(
  parameter int FLOOR_W = FLOOR_W_D
) (
  input  logic [FLOOR_W-1:0] i_prev,
  input  logic [FLOOR_W-1:0] i_cur,
  input  logic [FLOOR_W-1:0] i_alvo,
  input  logic               i_dir,
  output logic               o_carona,
  output logic               o_mesmo_andar,
  output logic               o_sentido_ok
);

  logic w_up;
  logic w_dn;
  logic w_entre_up;
  logic w_entre_dn;

  assign w_up = i_cur > i_prev;
  assign w_dn = i_cur < i_prev;

  assign w_entre_up = (i_alvo > i_prev) &&
                      (i_alvo < i_cur);
  assign w_entre_dn = (i_alvo < i_prev) &&
                      (i_alvo > i_cur);

  // a flat leg has no direction
  assign o_sentido_ok = i_dir ? w_up : w_dn;

  assign o_carona = o_sentido_ok &&
                    (w_up ? w_entre_up
                          : w_entre_dn);

  assign o_mesmo_andar = i_cur == i_alvo;

endmodule

// File: rtl/fila_carona_param.sv
// fila_carona_param: elevator stop queue
// places pickup/drop pairs en route
module fila_carona_param
  import fila_carona_param_pkg::*;
#(
  parameter int FLOOR_W = FLOOR_W_D,
  parameter int TYPE_W  = TYPE_W_D,
  parameter int DEPTH   = DEPTH_D,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  fila_carona_param_if.slave        bus,
  input  logic [FLOOR_W-1:0]        andar_atual,
  output logic [ADDR_W:0]           count,
  output logic                      full,
  output logic                      busy,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [TYPE_W+FLOOR_W:0]   rd_data
);

  localparam int EW        = 1 + TYPE_W + FLOOR_W;
  localparam int EO_BIT    = EW - 1;
  localparam int TIPO_LSB  = FLOOR_W;
  localparam int ANDAR_LSB = 0;
  localparam int CW        = ADDR_W + 1;

  logic [EW-1:0]      r_ent [DEPTH];
  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      r_idx;
  logic [CW-1:0]      r_pos;
  logic [FLOOR_W-1:0] r_origem;
  logic [FLOOR_W-1:0] r_destino;
  logic [TYPE_W-1:0]  r_tipo;
  logic               r_dir;

  logic               w_idle;
  logic               w_empty;
  logic               w_full;
  logic               w_pop_go;
  logic               w_req_go;
  logic               w_scan_o;
  logic               w_ins_o;
  logic               w_at_end;
  logic [ADDR_W-1:0]  w_ia;
  logic [ADDR_W-1:0]  w_prev_ia;
  logic [EW-1:0]      w_cur_e;
  logic [FLOOR_W-1:0] w_prev;
  logic [FLOOR_W-1:0] w_cur;
  logic [FLOOR_W-1:0] w_alvo;
  logic               w_carona;
  logic               w_mesmo;
  logic               w_sentido;
  logic               w_merge;
  logic [EW-1:0]      w_new;
  logic [EW-1:0]      w_head;

  assign w_idle   = r_state == S_IDLE;
  assign w_empty  = r_count == '0;
  assign w_full   = r_count > CW'(DEPTH - 2);
  assign w_pop_go = w_idle && !w_empty &&
                    bus.pop;
  assign w_req_go = bus.req_valid &&
                    bus.req_ready;
  assign w_scan_o = r_state == S_SCAN_O;
  assign w_ins_o  = r_state == S_INS_O;
  assign w_at_end = r_idx == r_count;

  assign w_ia      = r_idx[ADDR_W-1:0];
  assign w_prev_ia = w_ia - 1'b1;
  assign w_cur_e   = r_ent[w_ia];
  assign w_cur     = w_cur_e[ANDAR_LSB +: FLOOR_W];
  assign w_prev    = (r_idx == '0) ? andar_atual
                   : r_ent[w_prev_ia][ANDAR_LSB +: FLOOR_W];
  assign w_alvo    = w_scan_o ? r_origem
                              : r_destino;

  fila_carona_param_janela #(
    .FLOOR_W (FLOOR_W)
  ) u_janela (
    .i_prev        (w_prev),
    .i_cur         (w_cur),
    .i_alvo        (w_alvo),
    .i_dir         (r_dir),
    .o_carona      (w_carona),
    .o_mesmo_andar (w_mesmo),
    .o_sentido_ok  (w_sentido)
  );

  assign w_merge = w_mesmo && w_sentido &&
    (w_cur_e[EO_BIT] == w_scan_o) &&
    (w_cur_e[TIPO_LSB +: TYPE_W] == r_tipo);

  assign w_new = {w_ins_o, r_tipo,
                  w_ins_o ? r_origem
                          : r_destino};

  // scan FSM plus shift-register storage
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_idx     <= '0;
      r_pos     <= '0;
      r_origem  <= '0;
      r_destino <= '0;
      r_tipo    <= '0;
      r_dir     <= 1'b0;
      for (int k = 0; k < DEPTH; k++)
        r_ent[k] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop_go) begin
            for (int k = 0; k < DEPTH-1; k++)
              r_ent[k] <= r_ent[k+1];
            r_ent[DEPTH-1] <= '0;
            r_count <= r_count - 1'b1;
          end else if (w_req_go) begin
            r_origem  <= bus.req_origem;
            r_destino <= bus.req_destino;
            r_tipo    <= bus.req_tipo;
            r_dir     <= bus.req_destino >
                         bus.req_origem;
            r_idx     <= '0;
            r_state   <= S_SCAN_O;
          end
        end
        S_SCAN_O, S_SCAN_D: begin
          if (w_at_end) begin
            r_pos   <= r_count;
            r_state <= w_scan_o ? S_INS_O
                                : S_INS_D;
          end else if (w_merge) begin
            r_pos   <= r_idx;
            r_state <= w_scan_o ? S_MERGE_O
                                : S_MERGE_D;
          end else if (w_carona) begin
            r_pos   <= r_idx;
            r_state <= w_scan_o ? S_INS_O
                                : S_INS_D;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_INS_O, S_INS_D: begin
          for (int k = 1; k < DEPTH; k++)
            if (CW'(k) > r_pos &&
                CW'(k) <= r_count)
              r_ent[k] <= r_ent[k-1];
          for (int k = 0; k < DEPTH; k++)
            if (CW'(k) == r_pos)
              r_ent[k] <= w_new;
          r_count <= r_count + 1'b1;
          r_idx   <= r_pos + 1'b1;
          r_state <= w_ins_o ? S_SCAN_D
                             : S_IDLE;
        end
        S_MERGE_O: begin
          r_idx   <= r_pos + 1'b1;
          r_state <= S_SCAN_D;
        end
        S_MERGE_D: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_head = r_ent[0];

  assign bus.req_ready = w_idle && !bus.pop &&
                         !w_full;
  assign bus.pop_ready = w_idle && !w_empty;
  assign bus.head_valid = !w_empty;
  assign bus.head_andar =
    w_head[ANDAR_LSB +: FLOOR_W];
  assign bus.head_eh_origem = w_head[EO_BIT];
  assign bus.head_tipo =
    w_head[TIPO_LSB +: TYPE_W];
  assign bus.sobe = !w_empty &&
    (w_head[ANDAR_LSB +: FLOOR_W] > andar_atual);

  assign count = r_count;
  assign full  = w_full;
  assign busy  = !w_idle;

  assign rd_data = ({1'b0, rd_addr} < r_count)
                 ? r_ent[rd_addr] : '0;

endmodule

// File: tb/tb_fila_carona_param.sv
// tb_fila_carona_param: directed bench
// hand-computed queue contents per scenario
`timescale 1ns/1ps
module tb_fila_carona_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] andar;
  logic [4:0] count;
  logic       full;
  logic       busy;
  logic [3:0] rd_addr;
  logic [4:0] rd_data;
  int         n_cmp = 0;
  int         n_bad = 0;

  fila_carona_param_if #(
    .FLOOR_W (2),
    .TYPE_W  (2)
  ) bus ();

  fila_carona_param #(
    .FLOOR_W (2),
    .TYPE_W  (2),
    .DEPTH   (16)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .bus         (bus),
    .andar_atual (andar),
    .count       (count),
    .full        (full),
    .busy        (busy),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.pop = 1'b0;
    bus.req_origem = '0;
    bus.req_destino = '0;
    bus.req_tipo = '0;
    andar = '0;
    rd_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_req(input logic [1:0] o,
                        input logic [1:0] d,
                        input logic [1:0] t,
                        output int cyc);
    int n;
    @(negedge clk);
    bus.req_origem = o;
    bus.req_destino = d;
    bus.req_tipo = t;
    bus.req_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (n >= 50) cyc = -1;
  endtask

  task automatic rd(input int k,
                    output logic [4:0] v);
    rd_addr = 4'(k);
    #1;
    v = rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.pop = 1'b0;
    bus.req_origem = '0;
    bus.req_destino = '0;
    bus.req_tipo = '0;
    andar = '0;
    rd_addr = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (count !== 5'd0) begin
      n_bad++;
      $display("FAIL rst_count got %0d want 0",
               count);
    end
    n_cmp++;
    if ({busy, full, bus.head_valid,
         bus.pop_ready, bus.sobe} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 00000",
               {busy, full, bus.head_valid,
                bus.pop_ready, bus.sobe});
    end
    n_cmp++;
    if ({bus.head_andar, bus.head_tipo,
         bus.head_eh_origem, rd_data} !== 10'b0) begin
      n_bad++;
      $display("FAIL rst_head got %b want 0",
               {bus.head_andar, bus.head_tipo,
                bus.head_eh_origem, rd_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready got %b want 1",
               bus.req_ready);
    end
  endtask

  task automatic test_append();
    int c;
    logic [4:0] v;
    logic [4:0] e [3];
    e = '{5'b1_01_00, 5'b0_01_11, 5'b0};
    do_reset();
    do_req(2'd0, 2'd3, 2'd1, c);
    n_cmp++;
    if (c < 1 || c > 4) begin
      n_bad++;
      $display("FAIL app_busy got %0d want 1..4", c);
    end
    n_cmp++;
    if (count !== 5'd2) begin
      n_bad++;
      $display("FAIL app_count got %0d want 2",
               count);
    end
    for (int k = 0; k < 3; k++) begin
      rd(k, v);
      n_cmp++;
      if (v !== e[k]) begin
        n_bad++;
        $display("FAIL app_ent%0d got %b want %b",
                 k, v, e[k]);
      end
    end
    n_cmp++;
    if ({bus.head_valid, bus.head_andar,
         bus.head_eh_origem, bus.head_tipo,
         bus.sobe, bus.pop_ready}
        !== 8'b1_00_1_01_0_1) begin
      n_bad++;
      $display("FAIL app_head got %b want 10010101",
               {bus.head_valid, bus.head_andar,
                bus.head_eh_origem, bus.head_tipo,
                bus.sobe, bus.pop_ready});
    end
  endtask

  task automatic test_carona_up();
    int c;
    logic [4:0] v;
    logic [4:0] e [4];
    e = '{5'b1_01_00, 5'b1_10_01,
          5'b0_10_10, 5'b0_01_11};
    do_reset();
    do_req(2'd0, 2'd3, 2'd1, c);
    do_req(2'd1, 2'd2, 2'd2, c);
    n_cmp++;
    if (c < 1 || c > 8) begin
      n_bad++;
      $display("FAIL up_busy got %0d want 1..8", c);
    end
    n_cmp++;
    if (count !== 5'd4) begin
      n_bad++;
      $display("FAIL up_count got %0d want 4",
               count);
    end
    for (int k = 0; k < 4; k++) begin
      rd(k, v);
      n_cmp++;
      if (v !== e[k]) begin
        n_bad++;
        $display("FAIL up_ent%0d got %b want %b",
                 k, v, e[k]);
      end
    end
  endtask

  task automatic test_carona_down();
    int c;
    logic [4:0] v;
    logic [4:0] e [4];
    e = '{5'b1_01_11, 5'b1_01_10,
          5'b0_01_01, 5'b0_01_00};
    do_reset();
    andar = 2'd3;
    do_req(2'd3, 2'd0, 2'd1, c);
    do_req(2'd2, 2'd1, 2'd1, c);
    n_cmp++;
    if (count !== 5'd4) begin
      n_bad++;
      $display("FAIL dn_count got %0d want 4",
               count);
    end
    for (int k = 0; k < 4; k++) begin
      rd(k, v);
      n_cmp++;
      if (v !== e[k]) begin
        n_bad++;
        $display("FAIL dn_ent%0d got %b want %b",
                 k, v, e[k]);
      end
    end
    n_cmp++;
    if (bus.sobe !== 1'b0) begin
      n_bad++;
      $display("FAIL dn_sobe_eq got %b want 0",
               bus.sobe);
    end
    andar = 2'd0;
    #1;
    n_cmp++;
    if (bus.sobe !== 1'b1) begin
      n_bad++;
      $display("FAIL dn_sobe_up got %b want 1",
               bus.sobe);
    end
  endtask

  task automatic test_merge();
    int c;
    logic [4:0] v;
    logic [4:0] e [5];
    do_reset();
    do_req(2'd1, 2'd3, 2'd1, c);
    do_req(2'd1, 2'd2, 2'd1, c);
    e = '{5'b1_01_01, 5'b0_01_10,
          5'b0_01_11, 5'b0, 5'b0};
    n_cmp++;
    if (count !== 5'd3) begin
      n_bad++;
      $display("FAIL mg_count got %0d want 3",
               count);
    end
    for (int k = 0; k < 4; k++) begin
      rd(k, v);
      n_cmp++;
      if (v !== e[k]) begin
        n_bad++;
        $display("FAIL mg_ent%0d got %b want %b",
                 k, v, e[k]);
      end
    end
    do_req(2'd1, 2'd2, 2'd2, c);
    e = '{5'b1_01_01, 5'b0_01_10, 5'b0_01_11,
          5'b1_10_01, 5'b0_10_10};
    n_cmp++;
    if (count !== 5'd5) begin
      n_bad++;
      $display("FAIL nomg_count got %0d want 5",
               count);
    end
    for (int k = 0; k < 5; k++) begin
      rd(k, v);
      n_cmp++;
      if (v !== e[k]) begin
        n_bad++;
        $display("FAIL nomg_ent%0d got %b want %b",
                 k, v, e[k]);
      end
    end
  endtask

  task automatic test_full_pop();
    int c;
    logic [4:0] v;
    do_reset();
    do_req(2'd1, 2'd3, 2'd1, c);
    do_req(2'd1, 2'd2, 2'd1, c);
    for (int r = 0; r < 5; r++)
      do_req(2'd0, 2'd1, 2'd3, c);
    n_cmp++;
    if ({count, full, bus.req_ready}
        !== {5'd13, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL f13 got %0d/%b/%b want 13/0/1",
               count, full, bus.req_ready);
    end
    do_req(2'd0, 2'd1, 2'd3, c);
    n_cmp++;
    if ({count, full, bus.req_ready}
        !== {5'd15, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL f15 got %0d/%b/%b want 15/1/0",
               count, full, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (count !== 5'd15 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL f_block got %0d/%b want 15/0",
               count, busy);
    end
    bus.req_valid = 1'b0;
    bus.pop = 1'b1;
    @(negedge clk);
    bus.pop = 1'b0;
    #1;
    n_cmp++;
    if ({count, full, bus.req_ready}
        !== {5'd14, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL f_pop got %0d/%b/%b want 14/0/1",
               count, full, bus.req_ready);
    end
    n_cmp++;
    if ({bus.head_andar, bus.head_eh_origem,
         bus.head_tipo} !== 5'b10_0_01) begin
      n_bad++;
      $display("FAIL f_head got %b want 10001",
               {bus.head_andar, bus.head_eh_origem,
                bus.head_tipo});
    end
    rd(13, v);
    n_cmp++;
    if (v !== 5'b0_11_01) begin
      n_bad++;
      $display("FAIL f_ent13 got %b want 01101", v);
    end
    rd(14, v);
    n_cmp++;
    if (v !== 5'b0) begin
      n_bad++;
      $display("FAIL f_ent14 got %b want 0", v);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [4:0] v;
    do_reset();
    do_req(2'd0, 2'd3, 2'd1, c);
    @(negedge clk);
    bus.req_origem = 2'd1;
    bus.req_destino = 2'd2;
    bus.req_tipo = 2'd2;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || count !== 5'd3) begin
      n_bad++;
      $display("FAIL mid_scan got %b/%0d want 1/3",
               busy, count);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({count, busy, bus.head_valid}
        !== 7'b0) begin
      n_bad++;
      $display("FAIL mid_rst got %0d/%b/%b want 0/0/0",
               count, busy, bus.head_valid);
    end
    rd(1, v);
    n_cmp++;
    if (v !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_ent1 got %b want 0", v);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_ready got %b want 1",
               bus.req_ready);
    end
  endtask

  task automatic test_pop_vs_req();
    int c;
    int n;
    logic [4:0] v;
    logic [4:0] e [3];
    e = '{5'b1_10_01, 5'b0_10_10, 5'b0_01_11};
    do_reset();
    do_req(2'd0, 2'd3, 2'd1, c);
    @(negedge clk);
    bus.pop = 1'b1;
    bus.req_origem = 2'd1;
    bus.req_destino = 2'd2;
    bus.req_tipo = 2'd2;
    bus.req_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0 ||
        bus.pop_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pv_ready got %b/%b want 0/1",
               bus.req_ready, bus.pop_ready);
    end
    @(negedge clk);
    bus.pop = 1'b0;
    #1;
    n_cmp++;
    if ({count, busy, bus.req_ready,
         bus.head_andar} !== {5'd1, 2'b01, 2'd3}) begin
      n_bad++;
      $display("FAIL pv_pop got %0d/%b/%b/%0d want 1/0/1/3",
               count, busy, bus.req_ready,
               bus.head_andar);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pv_accept got %b want 1", busy);
    end
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n < 1 || n > 6) begin
      n_bad++;
      $display("FAIL pv_lat got %0d want 1..6", n);
    end
    n_cmp++;
    if (count !== 5'd3) begin
      n_bad++;
      $display("FAIL pv_count got %0d want 3",
               count);
    end
    for (int k = 0; k < 3; k++) begin
      rd(k, v);
      n_cmp++;
      if (v !== e[k]) begin
        n_bad++;
        $display("FAIL pv_ent%0d got %b want %b",
                 k, v, e[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_append();
    test_carona_up();
    test_carona_down();
    test_merge();
    test_full_pop();
    test_reset_mid();
    test_pop_vs_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
